hazard_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline hazard logic.
package mips_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_sel.sv
// E-stage operand forwarding select: one source register against the M and W writers.
module fwd_sel
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // M is the younger producer, so it wins over W.
    always_comb begin
        fwd = FWD_RF;
        if (src != REG_ZERO && reg_write_m && src == write_reg_m) begin
            fwd = FWD_M;
        end else if (src != REG_ZERO && reg_write_w && src == write_reg_w) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stall, branch/jump
// flushes and a whole-pipeline hold while a data-memory access is outstanding.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcM,
    input  logic             JumpD,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_wait;
    logic              lwstall;
    logic [1:0]        fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .src         (RsE),
        .write_reg_m (WriteRegM),
        .reg_write_m (RegWriteM),
        .write_reg_w (WriteRegW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src         (RtE),
        .write_reg_m (WriteRegM),
        .reg_write_m (RegWriteM),
        .write_reg_w (WriteRegW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign lwstall = MemtoRegE && (WriteRegE != REG_ZERO) &&
                     (WriteRegE == RsD || WriteRegE == RtD);

    // mem_wait is combinational so the very first miss cycle already holds the pipe.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        mem_wait = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d  = MWAIT;
                    mem_wait = 1'b1;
                end
            end
            MWAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    mem_wait = 1'b1;
                    if (wcnt_q != TIMEOUT_V) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
        mem_err_d = mem_err_q || (wcnt_d == TIMEOUT_V);
    end

    // Priority: mem_wait > branch > load-use > jump. Everything is forced idle in reset.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        if (rst_n) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcM) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
            end else if (lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (JumpD) begin
                FlushD = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl;
    import mips_pkg::*;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 16;

    // obs layout: {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
    localparam logic [11:0] X_IDLE = 12'h000;
    localparam logic [11:0] X_LW   = 12'h0C4;
    localparam logic [11:0] X_BR   = 12'h00E;
    localparam logic [11:0] X_JMP  = 12'h008;
    localparam logic [11:0] X_MW   = 12'h0F1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic             MemtoRegE, RegWriteM, RegWriteW, PCSrcM, JumpD, dmem_req, dmem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [11:0]      obs;

    logic [11:0] sb[$];
    logic [11:0] e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          model_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .MemtoRegE  (MemtoRegE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcM     (PCSrcM),
        .JumpD      (JumpD),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt)
    );

    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushM, FlushW};

    task automatic clear_inputs;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcM = 0; JumpD = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        RsE = 2; WriteRegM = 2; RegWriteM = 1; PCSrcM = 1; dmem_req = 1;
        MemtoRegE = 1; WriteRegE = 3; RsD = 3;
        sb.push_back(X_IDLE);
        @(negedge clk); #2;
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, e);
        end
        n_cmp++;
        if (mem_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_err: got %b want 0", mem_err);
        end
        n_cmp++;
        if (stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        model_cnt = 0;
    endtask

    task automatic test_forward;
        logic [1:0] fa, fb;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            case (i)
                0: begin RsE = 2; WriteRegM = 2; RegWriteM = 1; fa = FWD_M; fb = FWD_RF; end
                1: begin RsE = 2; WriteRegW = 2; RegWriteW = 1; fa = FWD_W; fb = FWD_RF; end
                2: begin RegWriteM = 1; RegWriteW = 1; fa = FWD_RF; fb = FWD_RF; end
                3: begin
                    RsE = 7; RtE = 7; WriteRegM = 7; RegWriteM = 1; WriteRegW = 7; RegWriteW = 1;
                    fa = FWD_M; fb = FWD_M;
                end
                4: begin RtE = 9; WriteRegM = 9; WriteRegW = 9; fa = FWD_RF; fb = FWD_RF; end
                default: begin
                    RsE = 3; RtE = 4; WriteRegM = 3; RegWriteM = 1; WriteRegW = 4; RegWriteW = 1;
                    fa = FWD_M; fb = FWD_W;
                end
            endcase
            sb.push_back({fa, fb, 8'h00});
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL forward_case%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_lwstall;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            case (i)
                0: begin MemtoRegE = 1; WriteRegE = 5; RtD = 5; sb.push_back(X_LW); end
                1: sb.push_back(X_IDLE);
                2: begin MemtoRegE = 1; WriteRegE = 6; RsD = 6; sb.push_back(X_LW); end
                default: begin MemtoRegE = 1; WriteRegE = 0; RsD = 0; sb.push_back(X_IDLE); end
            endcase
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL lwstall_case%0d: got %h want %h", i, obs, e);
            end
            n_cmp++;
            if (stall_cnt !== CNT_W'(model_cnt)) begin
                n_fail++; $display("FAIL lwstall_cnt%0d: got %0d want %0d", i, stall_cnt, model_cnt);
            end
            model_cnt += int'(e[7]);
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            case (i)
                0: begin PCSrcM = 1; MemtoRegE = 1; WriteRegE = 5; RtD = 5; sb.push_back(X_BR); end
                1: begin JumpD = 1; sb.push_back(X_JMP); end
                2: begin JumpD = 1; MemtoRegE = 1; WriteRegE = 8; RsD = 8; sb.push_back(X_LW); end
                default: begin PCSrcM = 1; JumpD = 1; sb.push_back(X_BR); end
            endcase
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL branch_case%0d: got %h want %h", i, obs, e);
            end
            model_cnt += int'(e[7]);
        end
    endtask

    task automatic test_mem_wait;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i < 3) begin
                dmem_req = 1; PCSrcM = 1; sb.push_back(X_MW);
            end else if (i == 3) begin
                dmem_req = 1; dmem_ready = 1; PCSrcM = 1; sb.push_back(X_BR);
            end else begin
                sb.push_back(X_IDLE);
            end
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL mem_wait_cycle%0d: got %h want %h", i, obs, e);
            end
            n_cmp++;
            if (stall_cnt !== CNT_W'(model_cnt)) begin
                n_fail++; $display("FAIL mem_wait_cnt%0d: got %0d want %0d", i, stall_cnt, model_cnt);
            end
            model_cnt += int'(e[7]);
        end
        n_cmp++;
        if (mem_err !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_err: got %b want 0", mem_err);
        end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < int'(TIMEOUT) + 3; i++) begin
            @(negedge clk);
            clear_inputs();
            dmem_req = 1;
            sb.push_back(X_MW);
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL timeout_wait%0d: got %h want %h", i, obs, e);
            end
            if (i == 4) begin
                n_cmp++;
                if (mem_err !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_early_err: got %b want 0", mem_err);
                end
            end
            model_cnt += int'(e[7]);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i == 0) begin
                dmem_req = 1; dmem_ready = 1;
            end
            sb.push_back(X_IDLE);
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL timeout_release%0d: got %h want %h", i, obs, e);
            end
            n_cmp++;
            if (mem_err !== 1'b1) begin
                n_fail++; $display("FAIL timeout_err_sticky%0d: got %b want 1", i, mem_err);
            end
        end
        n_cmp++;
        if (stall_cnt !== CNT_W'(model_cnt)) begin
            n_fail++; $display("FAIL timeout_cnt: got %0d want %0d", stall_cnt, model_cnt);
        end
    endtask

    task automatic test_reset_mid_wait;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_inputs();
            dmem_req = 1;
            sb.push_back(X_MW);
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL midrst_wait%0d: got %h want %h", i, obs, e);
            end
        end
        PCSrcM = 1; JumpD = 1;
        #1;
        rst_n = 1'b0;
        sb.push_back(X_IDLE);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++; $display("FAIL midrst_outputs: got %h want %h", obs, e);
        end
        n_cmp++;
        if (mem_err !== 1'b0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL midrst_state: got err=%b cnt=%0d want err=0 cnt=0",
                               mem_err, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        model_cnt = 0;
        sb.push_back(X_IDLE);
        #2;
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++; $display("FAIL midrst_run: got %h want %h", obs, e);
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== CNT_W'(model_cnt)) begin
            n_fail++; $display("FAIL midrst_cnt: got %0d want %0d", stall_cnt, model_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_lwstall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
